// File: rtl/rf_dump.sv
// rf_dump: streams a range of register-file words out over a byte interface.
// Each register is sent as one header byte (its address) followed by its data
// bytes, most significant byte first. The range wraps through the top address
// when first_a > last_a. abort and reset drop the dump without a done pulse.
module rf_dump #(
   parameter int WIDTH     = 32,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_SIZE-1:0] first_a,
   input  logic [ADDR_SIZE-1:0] last_a,
   output logic [ADDR_SIZE-1:0] rt,
   input  logic [WIDTH-1:0]     dt,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int NBYTES = WIDTH / 8;
   // Byte index runs 0 (header) .. NBYTES (last data byte).
   localparam int IDX_W  = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] rt_q, rt_d;
   logic [ADDR_SIZE-1:0] last_q, last_d;
   logic [WIDTH-1:0]     snap_q, snap_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 done_q, done_d;
   logic                 last_byte;

   assign last_byte = (idx_q == IDX_W'(NBYTES));

   // State and datapath registers; every register returns to zero on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rt_q    <= '0;
         last_q  <= '0;
         snap_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values computed by the combinational block.
         state_q <= state_d;
         rt_q    <= rt_d;
         last_q  <= last_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: abort wins, otherwise step through IDLE -> LOAD -> SEND.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      state_d = state_q;
      rt_d    = rt_q;
      last_d  = last_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      done_d  = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  rt_d    = first_a;
                  last_d  = last_a;
                  state_d = LOAD;
               end
            end
            LOAD: begin
               // dt is a combinational read of rt; freeze it for this register.
               snap_d  = dt;
               idx_d   = '0;
               state_d = SEND;
            end
            SEND: begin
               if (tx_ready) begin
                  if (last_byte) begin
                     if (rt_q == last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else begin
                        rt_d    = rt_q + ADDR_SIZE'(1);
                        state_d = LOAD;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                     // The header does not consume snapshot bits; data bytes shift out.
                     if (idx_q != '0) begin
                        snap_d = snap_q << 8;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs decode directly from registers, so they are stable during a stall.
   always_comb begin
      tx_valid = (state_q == SEND);
      tx_data  = 8'h00;
      if (tx_valid) begin
         tx_data = (idx_q == '0) ? 8'(rt_q) : snap_q[WIDTH-1 -: 8];
      end
      busy = (state_q != IDLE);
      done = done_q;
      rt   = rt_q;
   end

endmodule

// File: tb/tb_rf_dump.sv
// Testbench for rf_dump: table of dump ranges plus hand-written corner cases
// (snapshot isolation, abort, mid-dump reset) and randomized dumps, all checked
// against a byte-stream model built directly from the register contents.
module tb_rf_dump;

   localparam int WIDTH     = 32;
   localparam int ADDR_SIZE = 4;
   localparam int NREGS     = 1 << ADDR_SIZE;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 abort;
   logic [ADDR_SIZE-1:0] first_a;
   logic [ADDR_SIZE-1:0] last_a;
   logic [ADDR_SIZE-1:0] rt;
   logic [WIDTH-1:0]     dt;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 busy;
   logic                 done;

   logic [WIDTH-1:0] regs [NREGS];
   assign dt = regs[rt];

   rf_dump #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_a(first_a), .last_a(last_a), .rt(rt), .dt(dt),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor on the falling edge: records bytes that the next rising edge
   // accepts, counts done/busy cycles and checks stability while stalled.
   logic [7:0] cap[$];
   int         done_cnt = 0;
   int         busy_cnt = 0;
   bit         prev_stall = 0;
   bit         prev_abort = 0;
   logic [7:0] prev_data = '0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && !prev_abort) begin
            check("hold_valid", 64'(tx_valid), 64'd1);
            check("hold_data", 64'(tx_data), 64'(prev_data));
         end
         if (tx_valid && tx_ready && !abort) cap.push_back(tx_data);
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_abort = abort;
      end
   end

   // Reference model: the expected stream for a range is simply, for each
   // address from first to last (wrapping), the address then its word MSB first.
   logic [7:0] exp_q[$];

   task automatic build_exp(input logic [ADDR_SIZE-1:0] f, input logic [ADDR_SIZE-1:0] l);
      int a;
      exp_q.delete();
      for (int n = 0; n < NREGS; n++) begin
         a = (int'(f) + n) % NREGS;
         exp_q.push_back(8'(a));
         for (int b = WIDTH / 8 - 1; b >= 0; b--) exp_q.push_back(regs[a][8*b +: 8]);
         if (a == int'(l)) break;
      end
   endtask

   task automatic compare_stream(input string name);
      check({name, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
         check($sformatf("%s_byte%0d", name, i), 64'(cap[i]), 64'(exp_q[i]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input logic [ADDR_SIZE-1:0] f, input logic [ADDR_SIZE-1:0] l);
      cap.delete();
      done_cnt = 0;
      busy_cnt = 0;
      first_a  = f;
      last_a   = l;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Runs the handshake until done; with noise, start/first_a/last_a wiggle
   // only while the block is busy, which must not disturb the dump.
   task automatic finish_dump(input bit rand_ready, input bit noise);
      bit got = 0;
      for (int c = 0; c < 4000; c++) begin
         tx_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
         if (noise && busy) begin
            start   = 1'($urandom % 2);
            first_a = ADDR_SIZE'($urandom);
            last_a  = ADDR_SIZE'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            got = 1;
            break;
         end
      end
      start    = 1'b0;
      tx_ready = 1'b1;
      if (!got) check("dump_timeout", 64'd0, 64'd1);
      tick();
      tick();
   endtask

   typedef struct {
      logic [ADDR_SIZE-1:0] f;
      logic [ADDR_SIZE-1:0] l;
      bit                   rand_ready;
      int                   nbytes;
      int                   nbusy;   // -1 when stalls make the count irregular
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{4'd3,  4'd3,  1'b0, 5,  6};
      vecs[1] = '{4'd14, 4'd1,  1'b0, 20, 24};
      vecs[2] = '{4'd3,  4'd3,  1'b1, 5,  -1};
      vecs[3] = '{4'd0,  4'd15, 1'b0, 80, 96};
      vecs[4] = '{4'd7,  4'd6,  1'b1, 80, -1};
      vecs[5] = '{4'd15, 4'd15, 1'b0, 5,  6};

      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      regs[3]  = 32'hDEADBEEF;
      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      first_a  = '0;
      last_a   = '0;
      tx_ready = 1'b1;
      #12;
      check("rst_rt", 64'(rt), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b1;
      tick();

      // Table of dump ranges.
      foreach (vecs[i]) begin
         build_exp(vecs[i].f, vecs[i].l);
         kick(vecs[i].f, vecs[i].l);
         finish_dump(vecs[i].rand_ready, 1'b0);
         compare_stream($sformatf("vec%0d", i));
         check($sformatf("vec%0d_count", i), 64'(cap.size()), 64'(vecs[i].nbytes));
         check($sformatf("vec%0d_done", i), 64'(done_cnt), 64'd1);
         if (vecs[i].nbusy >= 0)
            check($sformatf("vec%0d_busy", i), 64'(busy_cnt), 64'(vecs[i].nbusy));
      end

      // dt changes after the LOAD cycle must not reach the stream.
      regs[5] = 32'h11111111;
      kick(4'd5, 4'd5);
      tick();
      regs[5] = 32'h22222222;
      finish_dump(1'b0, 1'b0);
      exp_q = '{8'h05, 8'h11, 8'h11, 8'h11, 8'h11};
      compare_stream("snapshot");

      // Abort after two accepted bytes.
      kick(4'd9, 4'd10);
      tx_ready = 1'b1;
      for (int c = 0; c < 100 && cap.size() < 2; c++) tick();
      tx_ready = 1'b0;
      abort    = 1'b1;
      tick();
      check("abort_valid", 64'(tx_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_nbytes", 64'(cap.size()), 64'd2);
      abort    = 1'b0;
      tx_ready = 1'b1;
      tick();
      tick();
      check("abort_no_done", 64'(done_cnt), 64'd0);
      build_exp(4'd2, 4'd2);
      kick(4'd2, 4'd2);
      finish_dump(1'b0, 1'b0);
      compare_stream("post_abort");
      check("post_abort_done", 64'(done_cnt), 64'd1);

      // Reset pulsed mid-SEND.
      kick(4'd0, 4'd3);
      for (int c = 0; c < 100 && cap.size() < 3; c++) tick();
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(tx_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_data", 64'(tx_data), 64'd0);
      check("mid_rst_rt", 64'(rt), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("post_rst_idle", 64'(busy), 64'd0);
      check("post_rst_no_done", 64'(done_cnt), 64'd0);
      build_exp(4'd4, 4'd5);
      kick(4'd4, 4'd5);
      finish_dump(1'b1, 1'b1);
      compare_stream("post_rst");
      check("post_rst_done", 64'(done_cnt), 64'd1);

      // Randomized ranges, data and back-pressure, with start noise while busy.
      for (int r = 0; r < 6; r++) begin
         logic [ADDR_SIZE-1:0] f, l;
         for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
         f = ADDR_SIZE'($urandom);
         l = ADDR_SIZE'($urandom);
         build_exp(f, l);
         kick(f, l);
         finish_dump(1'b1, 1'b1);
         compare_stream($sformatf("rand%0d", r));
         check($sformatf("rand%0d_done", r), 64'(done_cnt), 64'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_dump.md
RF_DUMP -- requirements
Module: rf_dump

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_SIZE, default 4, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate dump; has priority over all other inputs except reset.
REQ-007 SHALL have port first_a  input  ADDR_SIZE  first register address of the dump range.
REQ-008 SHALL have port last_a  input  ADDR_SIZE  last register address of the dump range, inclusive.
REQ-009 SHALL have port rt  output  ADDR_SIZE  register-file read address, registered.
REQ-010 SHALL have port dt  input  WIDTH  register-file read data for rt, combinational from rt.
REQ-011 SHALL have port tx_data  output  8  byte-stream data.
REQ-012 SHALL have port tx_valid  output  1  tx_data valid.
REQ-013 SHALL have port tx_ready  input  1  sink accepts byte when tx_valid and tx_ready are both high at a rising edge.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SEND.
REQ-017 In IDLE with start=1 and abort=0, SHALL latch first_a into rt, latch last_a internally, and enter LOAD on the next edge.
REQ-018 In LOAD, SHALL capture dt into a WIDTH-bit snapshot register, set the byte index to 0, and enter SEND on the next edge (exactly one cycle in LOAD).
REQ-019 In SEND, tx_valid SHALL be 1; byte 0 SHALL be the header {zero-pad, rt}, and bytes 1..WIDTH/8 SHALL be the snapshot, MSB byte first.
REQ-020 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-021 Each accepted byte SHALL advance the byte index by one; a byte SHALL NOT be emitted twice or skipped.
REQ-022 On acceptance of the last byte (index WIDTH/8) with rt != latched last_a, SHALL increment rt modulo 2^ADDR_SIZE and enter LOAD.
REQ-023 On acceptance of the last byte with rt == latched last_a, SHALL enter IDLE and assert done for exactly that following cycle.
REQ-024 first_a > last_a SHALL wrap through the top address to 0 (for example, 14,15,0,1 for first_a=14, last_a=1).
REQ-025 first_a == last_a SHALL dump exactly one register.
REQ-026 start while busy=1 SHALL be ignored; first_a and last_a changes after the start cycle SHALL have no effect.
REQ-027 Changes on dt after the LOAD cycle SHALL NOT alter emitted bytes for that register.
REQ-028 abort=1 in any state SHALL enter IDLE on the next edge with tx_valid=0 and no done pulse; dropping tx_valid without a handshake is permitted only on abort.
REQ-029 Per register, minimum latency SHALL be 1 LOAD cycle plus 1+WIDTH/8 SEND cycles (6 cycles at WIDTH=32 with tx_ready held at 1).

Reset
REQ-030 While reset=0, SHALL asynchronously force state=IDLE, rt=0, tx_data=0, tx_valid=0, busy=0, done=0, snapshot=0, and byte index=0.
REQ-031 Reset asserted mid-dump SHALL abandon the dump with no done pulse; after release, SHALL wait in IDLE for a new start.

Verification
REQ-032 first_a=3, last_a=3, reg3=0xDEADBEEF, tx_ready=1 -> bytes 03,DE,AD,BE,EF; done pulses once; busy high for 6 cycles.
REQ-033 first_a=14, last_a=1 -> headers 0E,0F,00,01 in order; 20 bytes total; one done pulse.
REQ-034 tx_ready toggled pseudo-randomly -> tx_data stable while stalled; byte sequence identical to the REQ-032 case.
REQ-035 dt changed from 0x11111111 to 0x22222222 during SEND of register 5 -> emitted bytes 05,11,11,11,11.
REQ-036 abort after 2 accepted bytes -> next cycle tx_valid=0, busy=0, and no done; a following start produces a complete dump.
REQ-037 reset pulsed low mid-SEND -> outputs reach reset values immediately; start is ignored during busy and honored after release.
